// File: rtl/frame_capture_if.sv
// Pixel stream and native memory bus signals of frame_capture.
// The slave modport is the capture block; the master modport drives pixels and bus requests.
interface frame_capture_if;
   logic [7:0]  pixel_in;
   logic        valid_in;
   logic        ready_out;
   logic        mem_valid;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        irq;

   modport master (
      output pixel_in, valid_in, mem_valid, mem_wstrb, mem_addr, mem_wdata,
      input  ready_out, mem_ready, mem_rdata, irq
   );

   modport slave (
      input  pixel_in, valid_in, mem_valid, mem_wstrb, mem_addr, mem_wdata,
      output ready_out, mem_ready, mem_rdata, irq
   );
endinterface

// File: rtl/frame_capture.sv
// Pixel stream sink that packs four pixels per word into a frame buffer.
// Control, status and the captured frame are exposed over the native memory bus.
module frame_capture #(
   parameter int FRAME_PIXELS = 1024
) (
   input logic            clk,
   input logic            rstn,
   frame_capture_if.slave bus
);

   localparam int WORDS = FRAME_PIXELS / 4;
   localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [12:0] LAST_PIXEL = 13'(FRAME_PIXELS - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t      state, state_next;
   logic [12:0] count;
   logic [23:0] pack;
   logic        done, irq_en;
   logic        mem_ready_q;
   logic [31:0] rdata_q;
   logic [31:0] read_value;
   logic [31:0] buffer [WORDS];
   logic        clear_frame, frame_done;

   logic        access, is_write, is_read, ctrl_wr, status_wr;
   logic        start, abort, transfer, last_beat;
   logic [10:0] word_addr;
   logic        unused_bits;

   assign word_addr   = bus.mem_addr[12:2];
   assign access      = bus.mem_valid && !mem_ready_q;
   assign is_write    = access && (|bus.mem_wstrb);
   assign is_read     = access && !(|bus.mem_wstrb);
   assign ctrl_wr     = is_write && (word_addr == 11'd0);
   assign status_wr   = is_write && (word_addr == 11'd1);
   assign abort       = ctrl_wr && bus.mem_wdata[1];
   assign start       = ctrl_wr && bus.mem_wdata[0] && !bus.mem_wdata[1];
   assign transfer    = bus.valid_in && (state == CAPTURE);
   assign last_beat   = transfer && (count == LAST_PIXEL);
   assign unused_bits = ^{bus.mem_addr[31:13], bus.mem_addr[1:0], bus.mem_wdata[31:3]};

   assign bus.ready_out = (state == CAPTURE);
   assign bus.mem_ready = mem_ready_q;
   assign bus.mem_rdata = rdata_q;
   assign bus.irq       = done && irq_en;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_next;
   end

   // ABORT always has priority; START is only honoured outside CAPTURE.
   always_comb begin
      state_next  = state;
      clear_frame = 1'b0;
      frame_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next  = CAPTURE;
               clear_frame = 1'b1;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_next = IDLE;
            end else if (last_beat) begin
               state_next = DONE;
               frame_done = 1'b1;
            end
         end
         DONE: begin
            if (abort) begin
               state_next = IDLE;
            end else if (start) begin
               state_next  = CAPTURE;
               clear_frame = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // COUNT doubles as the pack index, so clearing it also discards a partial word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count  <= '0;
         pack   <= '0;
         done   <= 1'b0;
         irq_en <= 1'b0;
      end else begin
         if (clear_frame)   count <= '0;
         else if (transfer) count <= count + 13'd1;
         if (transfer) pack <= {bus.pixel_in, pack[23:8]};
         if (clear_frame)                            done <= 1'b0;
         else if (frame_done)                        done <= 1'b1;
         else if (status_wr && bus.mem_wdata[1])     done <= 1'b0;
         if (ctrl_wr) irq_en <= bus.mem_wdata[2];
      end
   end

   always_ff @(posedge clk) begin
      if (transfer && (count[1:0] == 2'b11))
         buffer[count[AW+1:2]] <= {bus.pixel_in, pack};
   end

   always_comb begin
      read_value = '0;
      if (word_addr[10]) begin
         if ({1'b0, word_addr[9:0]} < 11'(WORDS))
            read_value = buffer[word_addr[AW-1:0]];
      end else begin
         case (word_addr[9:0])
            10'd0:   read_value = {29'd0, irq_en, 2'b00};
            10'd1:   read_value = {30'd0, done, state == CAPTURE};
            10'd2:   read_value = {19'd0, count};
            default: read_value = '0;
         endcase
      end
   end

   // One-cycle acknowledge; a request still held during the ack cycle is not re-accepted.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_ready_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         mem_ready_q <= access;
         rdata_q     <= is_read ? read_value : 32'd0;
      end
   end

endmodule

// File: tb/tb_frame_capture.sv
// Randomized scoreboard bench for frame_capture: bus responses are queued at issue time
// from a frame-level reference model and checked by a monitor when mem_ready appears.
module tb_frame_capture;

   localparam int FP    = 1024;
   localparam int WORDS = FP / 4;

   typedef struct {
      logic [31:0] value;
      bit          care;
      string       name;
   } exp_t;

   typedef enum {M_IDLE, M_CAPTURE, M_DONE} model_state_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   frame_capture_if bus ();

   frame_capture #(.FRAME_PIXELS(FP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int           checks = 0;
   int           errors = 0;
   exp_t         sbq[$];
   exp_t         mon_e;

   model_state_t m_state = M_IDLE;
   int           m_count = 0;
   bit           m_done = 1'b0;
   bit           m_irq_en = 1'b0;
   logic [7:0]   frame_pix[$];
   logic [31:0]  m_buf [WORDS];
   bit           m_known [WORDS];

   task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic check_output();
      check_value("ready_out", 32'(bus.ready_out), 32'(m_state == M_CAPTURE));
      check_value("irq", 32'(bus.irq), 32'(m_done && m_irq_en));
   endtask

   // Bus responses are compared in arrival order against what was queued at issue.
   always @(negedge clk) begin
      if (rstn && bus.mem_ready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: got mem_ready=1 expected no pending request");
         end else begin
            mon_e = sbq.pop_front();
            if (mon_e.care) check_value(mon_e.name, bus.mem_rdata, mon_e.value);
         end
      end
   end

   function automatic exp_t model_read(input logic [12:0] offset);
      exp_t e;
      e.care  = 1'b1;
      e.value = 32'd0;
      e.name  = $sformatf("read_%03h", offset);
      if (offset >= 13'h1000) begin
         int k;
         k = (int'(offset) - 'h1000) / 4;
         if (k < WORDS) begin
            e.value = m_buf[k];
            e.care  = m_known[k];
         end
      end else if (offset == 13'h000) begin
         e.value = {29'd0, m_irq_en, 2'b00};
      end else if (offset == 13'h004) begin
         e.value = {30'd0, m_done, m_state == M_CAPTURE};
      end else if (offset == 13'h008) begin
         e.value = 32'(m_count);
      end
      return e;
   endfunction

   task automatic model_write(input logic [12:0] offset, input logic [31:0] wdata);
      if (offset == 13'h000) begin
         m_irq_en = wdata[2];
         if (wdata[1]) begin
            m_state = M_IDLE;
         end else if (wdata[0] && m_state != M_CAPTURE) begin
            m_state = M_CAPTURE;
            m_count = 0;
            m_done  = 1'b0;
            frame_pix.delete();
         end
      end else if (offset == 13'h004 && wdata[1]) begin
         m_done = 1'b0;
      end
   endtask

   task automatic model_accept(input logic [7:0] px);
      int k;
      frame_pix.push_back(px);
      m_count++;
      if (frame_pix.size() % 4 == 0) begin
         k = frame_pix.size() / 4 - 1;
         m_buf[k]   = {frame_pix[4*k+3], frame_pix[4*k+2], frame_pix[4*k+1], frame_pix[4*k]};
         m_known[k] = 1'b1;
      end
      if (m_count == FP) begin
         m_state = M_DONE;
         m_done  = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_state  = M_IDLE;
      m_count  = 0;
      m_done   = 1'b0;
      m_irq_en = 1'b0;
      frame_pix.delete();
      for (int i = 0; i < WORDS; i++) m_known[i] = 1'b0;
   endtask

   task automatic bus_cycle(input bit is_wr, input logic [12:0] offset, input logic [31:0] wdata, input bit hold_two);
      logic [31:0] a;
      a       = $urandom();
      a[12:0] = offset;
      @(negedge clk);
      bus.mem_valid = 1'b1;
      bus.mem_wstrb = is_wr ? 4'($urandom_range(1, 15)) : 4'h0;
      bus.mem_addr  = a;
      bus.mem_wdata = wdata;
      @(posedge clk);
      if (is_wr) model_write(offset, wdata);
      if (hold_two) @(posedge clk);
      @(negedge clk);
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = 4'h0;
   endtask

   task automatic bus_read(input logic [12:0] offset, input bit hold_two);
      sbq.push_back(model_read(offset));
      bus_cycle(1'b0, offset, 32'($urandom()), hold_two);
   endtask

   task automatic bus_read_const(input logic [12:0] offset, input logic [31:0] value);
      exp_t e;
      e.value = value;
      e.care  = 1'b1;
      e.name  = $sformatf("read_const_%03h", offset);
      sbq.push_back(e);
      bus_cycle(1'b0, offset, 32'($urandom()), 1'b0);
   endtask

   task automatic bus_write(input logic [12:0] offset, input logic [31:0] wdata);
      exp_t e;
      e.value = 32'd0;
      e.care  = 1'b1;
      e.name  = $sformatf("write_rdata_%03h", offset);
      sbq.push_back(e);
      bus_cycle(1'b1, offset, wdata, 1'b0);
   endtask

   // Streams n accepted pixels valued (index + seed); gap_pct percent of cycles idle.
   task automatic apply_stimulus(input int n, input logic [7:0] seed, input int gap_pct);
      int accepted = 0;
      int cycles   = 0;
      int budget   = n * 10 + 100;
      while (accepted < n && cycles < budget) begin
         @(negedge clk);
         cycles++;
         check_value("ready_out_stream", 32'(bus.ready_out), 32'(m_state == M_CAPTURE));
         bus.valid_in = ($urandom_range(0, 99) >= gap_pct);
         bus.pixel_in = bus.valid_in ? 8'(m_count) + seed : 8'($urandom());
         @(posedge clk);
         if (bus.valid_in && m_state == M_CAPTURE) begin
            model_accept(bus.pixel_in);
            accepted++;
         end
      end
      if (accepted < n) begin
         checks++;
         errors++;
         $display("[TB] FAIL stream_timeout: got %0d pixels accepted expected %0d", accepted, n);
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      check_output();
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got simulation still running expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.pixel_in  = '0;
      bus.valid_in  = 1'b0;
      bus.mem_valid = 1'b0;
      bus.mem_wstrb = '0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_output();
      check_value("reset_mem_ready", 32'(bus.mem_ready), 32'd0);
      check_value("reset_mem_rdata", bus.mem_rdata, 32'd0);
      bus_read_const(13'h004, 32'h0);
      bus_read_const(13'h008, 32'h0);
      bus_read(13'h000, 1'b0);

      $display("[TB] full-rate capture with irq enabled");
      bus_write(13'h000, 32'h5);
      apply_stimulus(FP, 8'h00, 0);
      bus_read_const(13'h004, 32'h2);
      bus_read_const(13'h008, 32'd1024);
      bus_read_const(13'h1000, 32'h03020100);
      bus_read_const(13'h13FC, 32'hFFFEFDFC);
      bus_read(13'h1200, 1'b0);

      $display("[TB] done write-1-clear");
      bus_write(13'h004, 32'h2);
      check_output();
      bus_read_const(13'h004, 32'h0);

      $display("[TB] gapped capture, shifted pattern");
      bus_write(13'h000, 32'h5);
      apply_stimulus(FP, 8'h37, 50);
      bus_read(13'h008, 1'b0);
      for (int i = 0; i < 8; i++) bus_read(13'h1000 + 13'(4 * $urandom_range(0, WORDS - 1)), 1'b0);

      $display("[TB] gapped capture, reference pattern");
      bus_write(13'h000, 32'h5);
      apply_stimulus(FP, 8'h00, 50);
      bus_read_const(13'h008, 32'd1024);
      bus_read_const(13'h1000, 32'h03020100);
      bus_read_const(13'h13FC, 32'hFFFEFDFC);

      $display("[TB] abort after six pixels");
      bus_write(13'h000, 32'h1);
      apply_stimulus(6, 8'h40, 30);
      bus_write(13'h000, 32'h2);
      check_output();
      bus_read_const(13'h004, 32'h0);
      bus_read_const(13'h008, 32'd6);
      bus_read_const(13'h1000, 32'h43424140);
      bus_read_const(13'h1004, 32'h07060504);

      $display("[TB] START and ABORT together in IDLE");
      bus_write(13'h000, 32'h3);
      check_output();
      bus_read_const(13'h004, 32'h0);

      $display("[TB] held request, unmapped and dropped accesses");
      bus_read(13'h008, 1'b1);
      bus_read_const(13'h00C, 32'h0);
      bus_read_const(13'h0FFC, 32'h0);
      bus_write(13'h1008, 32'($urandom()));
      bus_read(13'h1008, 1'b0);

      $display("[TB] reset in the middle of a capture");
      bus_write(13'h000, 32'h5);
      apply_stimulus(500, 8'h11, 0);
      #2 rstn = 1'b0;
      #1;
      model_reset();
      check_output();
      check_value("midreset_mem_ready", 32'(bus.mem_ready), 32'd0);
      check_value("midreset_mem_rdata", bus.mem_rdata, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      bus_read_const(13'h004, 32'h0);
      bus_read_const(13'h008, 32'h0);
      bus_write(13'h000, 32'h1);
      apply_stimulus(8, 8'h20, 20);
      bus_read_const(13'h008, 32'd8);
      bus_write(13'h000, 32'h2);
      bus_read(13'h1000, 1'b0);
      bus_read(13'h1004, 1'b0);

      repeat (4) @(negedge clk);
      check_value("scoreboard_drain", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
